// File: rtl/bch_gf_pkg.sv
// GF(2^5) arithmetic and shared types for the BCH(31,k) t=3 front end.
// Provides multiply, table inverse, alpha-power table and decoder types.
package bch_gf_pkg;

  localparam int M  = 5;
  localparam int N  = 31;
  localparam int T  = 3;
  localparam int NS = 2 * T;
  // C(x) and B(x) carry one guard term above degree T.
  localparam int CW = T + 2;

  // x^5 + x^2 + 1 with the x^5 term implied.
  localparam logic [M-1:0] PRIM = 5'b00101;

  typedef logic [M-1:0] gf_t;
  typedef logic [NS-1:0][M-1:0] syn_t;
  typedef logic [CW-1:0][M-1:0] poly_t;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_ITER,
    ST_DONE
  } state_e;

  function automatic gf_t gf_mul(
    input gf_t a,
    input gf_t b
  );
    gf_t p;
    gf_t x;
    p = '0;
    x = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ x;
      x = x[M-1] ? ((x << 1) ^ PRIM) : (x << 1);
    end
    return p;
  endfunction

  function automatic gf_t gf_inv(input gf_t a);
    case (a)
      5'd1:    return 5'd1;
      5'd2:    return 5'd18;
      5'd3:    return 5'd28;
      5'd4:    return 5'd9;
      5'd5:    return 5'd23;
      5'd6:    return 5'd14;
      5'd7:    return 5'd12;
      5'd8:    return 5'd22;
      5'd9:    return 5'd4;
      5'd10:   return 5'd25;
      5'd11:   return 5'd16;
      5'd12:   return 5'd7;
      5'd13:   return 5'd15;
      5'd14:   return 5'd6;
      5'd15:   return 5'd13;
      5'd16:   return 5'd11;
      5'd17:   return 5'd24;
      5'd18:   return 5'd2;
      5'd19:   return 5'd29;
      5'd20:   return 5'd30;
      5'd21:   return 5'd26;
      5'd22:   return 5'd8;
      5'd23:   return 5'd5;
      5'd24:   return 5'd17;
      5'd25:   return 5'd10;
      5'd26:   return 5'd21;
      5'd27:   return 5'd31;
      5'd28:   return 5'd3;
      5'd29:   return 5'd19;
      5'd30:   return 5'd20;
      5'd31:   return 5'd27;
      default: return 5'd0;
    endcase
  endfunction

  // alpha^e; e = 31 wraps to alpha^0.
  function automatic gf_t gf_alpha_pow(input logic [4:0] e);
    case (e)
      5'd0:    return 5'd1;
      5'd1:    return 5'd2;
      5'd2:    return 5'd4;
      5'd3:    return 5'd8;
      5'd4:    return 5'd16;
      5'd5:    return 5'd5;
      5'd6:    return 5'd10;
      5'd7:    return 5'd20;
      5'd8:    return 5'd13;
      5'd9:    return 5'd26;
      5'd10:   return 5'd17;
      5'd11:   return 5'd7;
      5'd12:   return 5'd14;
      5'd13:   return 5'd28;
      5'd14:   return 5'd29;
      5'd15:   return 5'd31;
      5'd16:   return 5'd27;
      5'd17:   return 5'd19;
      5'd18:   return 5'd3;
      5'd19:   return 5'd6;
      5'd20:   return 5'd12;
      5'd21:   return 5'd24;
      5'd22:   return 5'd21;
      5'd23:   return 5'd15;
      5'd24:   return 5'd30;
      5'd25:   return 5'd25;
      5'd26:   return 5'd23;
      5'd27:   return 5'd11;
      5'd28:   return 5'd22;
      5'd29:   return 5'd9;
      5'd30:   return 5'd18;
      default: return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/bch_syndrome_calc.sv
// Combinational syndromes S1..S6 of a received 31-bit word.
// Ports: r (bit i = coeff of x^i) in, syn[j-1] = r(alpha^j) out.
module bch_syndrome_calc
  import bch_gf_pkg::*;
(
  input  logic [N-1:0] r,
  output syn_t         syn
);

  always_comb begin
    syn = '0;
    for (int j = 1; j <= NS; j++) begin
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          syn[j-1] = syn[j-1] ^
            gf_alpha_pow(5'((i * j) % N));
        end
      end
    end
  end

endmodule

// File: rtl/bch_syndrome_bm_decoder.sv
// BCH(31,k) t=3 front end: syndromes plus Berlekamp-Massey, one step/clk.
// Ports: clk, reset (sync, high), r in; syndrome1..6, sigma0..3, L, done out.
module bch_syndrome_bm_decoder
  import bch_gf_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] r,
  output logic [M-1:0] syndrome1,
  output logic [M-1:0] syndrome2,
  output logic [M-1:0] syndrome3,
  output logic [M-1:0] syndrome4,
  output logic [M-1:0] syndrome5,
  output logic [M-1:0] syndrome6,
  output logic [M-1:0] sigma0,
  output logic [M-1:0] sigma1,
  output logic [M-1:0] sigma2,
  output logic [M-1:0] sigma3,
  output logic [3:0]   L,
  output logic         done
);

  syn_t syn_w;

  bch_syndrome_calc u_syn (
    .r   (r),
    .syn (syn_w)
  );

  state_e     state_q, state_d;
  syn_t       s_q, s_d;
  poly_t      c_q, c_d;
  poly_t      bp_q, bp_d;
  gf_t        b_q, b_d;
  logic [3:0] mm_q, mm_d;
  logic [2:0] k_q, k_d;
  logic [3:0] l_q, l_d;
  logic       done_q, done_d;

  gf_t   disc;
  gf_t   coef;
  poly_t upd;
  logic  grow;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    bp_d    = bp_q;
    b_d     = b_q;
    mm_d    = mm_q;
    k_d     = k_q;
    l_d     = l_q;
    done_d  = done_q;

    // d = S(k+1) + sum C_i * S(k+1-i), i = 1..L
    disc = '0;
    for (int n = 0; n < NS; n++) begin
      if (n == int'(k_q)) disc = s_q[n];
    end
    for (int i = 1; i < CW; i++) begin
      for (int n = 0; n < NS; n++) begin
        if (i <= int'(l_q) && n + i == int'(k_q)) begin
          disc = disc ^ gf_mul(c_q[i], s_q[n]);
        end
      end
    end

    // C + d/b * x^mm * B, truncated to CW terms
    coef = gf_mul(disc, gf_inv(b_q));
    upd  = c_q;
    for (int j = 0; j < CW; j++) begin
      for (int i = 0; i < CW; i++) begin
        if (i + int'(mm_q) == j) begin
          upd[j] = upd[j] ^ gf_mul(coef, bp_q[i]);
        end
      end
    end

    grow = (disc != '0) &&
           (2 * int'(l_q) <= int'(k_q));

    unique case (state_q)
      ST_LOAD: begin
        s_d     = syn_w;
        k_d     = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        if (disc == '0) begin
          mm_d = mm_q + 4'd1;
        end else if (grow) begin
          c_d  = upd;
          bp_d = c_q;
          b_d  = disc;
          l_d  = 4'(k_q) + 4'd1 - l_q;
          mm_d = 4'd1;
        end else begin
          c_d  = upd;
          mm_d = mm_q + 4'd1;
        end
        if (k_q == 3'(NS - 1)) state_d = ST_DONE;
        else k_d = k_q + 3'd1;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOAD;
      s_q     <= '0;
      c_q     <= poly_t'(1);
      bp_q    <= poly_t'(1);
      b_q     <= 5'd1;
      mm_q    <= 4'd1;
      k_q     <= '0;
      l_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      bp_q    <= bp_d;
      b_q     <= b_d;
      mm_q    <= mm_d;
      k_q     <= k_d;
      l_q     <= l_d;
      done_q  <= done_d;
    end
  end

  assign syndrome1 = syn_w[0];
  assign syndrome2 = syn_w[1];
  assign syndrome3 = syn_w[2];
  assign syndrome4 = syn_w[3];
  assign syndrome5 = syn_w[4];
  assign syndrome6 = syn_w[5];

  assign sigma0 = c_q[0];
  assign sigma1 = c_q[1];
  assign sigma2 = c_q[2];
  assign sigma3 = c_q[3];
  assign L      = l_q;
  assign done   = done_q;

endmodule

// File: tb/tb_bch_syndrome_bm_decoder.sv
// Directed bench for bch_syndrome_bm_decoder.
// Hand-computed syndromes, sigma and L for small error patterns.
module tb_bch_syndrome_bm_decoder;

  logic        clk;
  logic        reset;
  logic [30:0] r;
  logic [4:0]  syndrome1, syndrome2, syndrome3;
  logic [4:0]  syndrome4, syndrome5, syndrome6;
  logic [4:0]  sigma0, sigma1, sigma2, sigma3;
  logic [3:0]  L;
  logic        done;

  int n_assert;
  int n_fail;

  bch_syndrome_bm_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .r         (r),
    .syndrome1 (syndrome1),
    .syndrome2 (syndrome2),
    .syndrome3 (syndrome3),
    .syndrome4 (syndrome4),
    .syndrome5 (syndrome5),
    .syndrome6 (syndrome6),
    .sigma0    (sigma0),
    .sigma1    (sigma1),
    .sigma2    (sigma2),
    .sigma3    (sigma3),
    .L         (L),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset for one edge, release, then check done timing.
  task automatic run(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    edges(7);
    chk({tag, "_done_e7"}, 8'(done), 8'd0);
    edges(1);
    chk({tag, "_done_e8"}, 8'(done), 8'd1);
  endtask

  task automatic chk_sig(
    input string tag,
    input int    s0,
    input int    s1,
    input int    s2,
    input int    s3,
    input int    l
  );
    chk({tag, "_sigma0"}, 8'(sigma0), 8'(s0));
    chk({tag, "_sigma1"}, 8'(sigma1), 8'(s1));
    chk({tag, "_sigma2"}, 8'(sigma2), 8'(s2));
    chk({tag, "_sigma3"}, 8'(sigma3), 8'(s3));
    chk({tag, "_L"},      8'(L),      8'(l));
  endtask

  task automatic chk_syn(
    input string tag,
    input int    a,
    input int    b,
    input int    c,
    input int    d,
    input int    e,
    input int    f
  );
    chk({tag, "_S1"}, 8'(syndrome1), 8'(a));
    chk({tag, "_S2"}, 8'(syndrome2), 8'(b));
    chk({tag, "_S3"}, 8'(syndrome3), 8'(c));
    chk({tag, "_S4"}, 8'(syndrome4), 8'(d));
    chk({tag, "_S5"}, 8'(syndrome5), 8'(e));
    chk({tag, "_S6"}, 8'(syndrome6), 8'(f));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    r        = '0;
    edges(2);

    // reset state
    chk("rst_done", 8'(done), 8'd0);
    chk_sig("rst", 1, 0, 0, 0, 0);

    // all-zero word
    r = '0;
    run("zero");
    chk_syn("zero", 0, 0, 0, 0, 0, 0);
    chk_sig("zero", 1, 0, 0, 0, 0);

    // single error at x^5
    r = 31'h20;
    run("one");
    chk_syn("one", 5, 17, 31, 12, 25, 18);
    chk_sig("one", 1, 5, 0, 0, 1);

    // two errors at x^0, x^1
    r = 31'h3;
    run("two");
    chk_syn("two", 3, 5, 9, 17, 4, 11);
    chk_sig("two", 1, 3, 2, 0, 2);

    // three errors at x^0..x^2; word cleared after LOAD
    r = 31'h7;
    #1;
    chk_syn("three", 7, 21, 3, 28, 21, 5);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    edges(1);
    r = '0;
    edges(6);
    chk("three_done_e7", 8'(done), 8'd0);
    edges(1);
    chk("three_done_e8", 8'(done), 8'd1);
    chk_sig("three", 1, 7, 14, 8, 3);

    // reset pulse at ITER step 3, new word bit 5
    r = 31'h3;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    edges(4);
    @(negedge clk);
    r     = 31'h20;
    reset = 1'b1;
    edges(1);
    chk("abort_done", 8'(done), 8'd0);
    chk_sig("abort", 1, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    edges(7);
    chk("abort_done_e7", 8'(done), 8'd0);
    edges(1);
    chk("abort_done_e8", 8'(done), 8'd1);
    chk_sig("abort", 1, 5, 0, 0, 1);

    // r change in DONE: outputs held, syndromes follow
    @(negedge clk);
    r = 31'h3;
    #1;
    chk("hold_S1", 8'(syndrome1), 8'd3);
    chk("hold_S2", 8'(syndrome2), 8'd5);
    edges(4);
    chk("hold_done", 8'(done), 8'd1);
    chk_sig("hold", 1, 5, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
